// File: rtl/gf2_poly_divider.sv
// Bit-serial carry-less (GF(2)[x]) long divider: A = Q*D xor R with deg(R) < deg(D).
// A degree scan of the divisor is followed by one dividend bit per cycle, MSB first.
module gf2_poly_divider #(
    parameter int N  = 521,
    parameter int DW = 2 * N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [N-1:0]  divisor,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] quotient,
    output logic [N-1:0]  remainder
);

    // state | meaning
    // IDLE  | waiting for start; results held on the outputs
    // FIND  | scanning divisor from MSB down for its leading one
    // DIV   | shifting in one dividend bit per cycle and reducing

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [KW-1:0] K_INIT = KW'(N - 1);
    localparam logic [IW-1:0] I_INIT = IW'(DW - 1);

    typedef enum logic [1:0] {IDLE, FIND, DIV} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-2:0]  r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] deg_q, deg_d;
    logic [IW-1:0] i_q, i_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  t;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        k_d     = k_q;
        deg_d   = deg_q;
        i_d     = i_q;
        done_d  = 1'b0;
        err_d   = err_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        // remainder stays below deg, so its top bit is never needed in the shift
        t       = {r_q, a_q[i_q]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = dividend;
                    d_d = divisor;
                    q_d = '0;
                    r_d = '0;
                    k_d = K_INIT;
                    if (divisor == '0) begin
                        err_d  = 1'b1;
                        quot_d = '0;
                        rem_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        state_d = FIND;
                    end
                end
            end
            FIND: begin
                if (d_q[k_q]) begin
                    deg_d   = k_q;
                    i_d     = I_INIT;
                    state_d = DIV;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            DIV: begin
                if (t[deg_q]) begin
                    r_d      = t[N-2:0] ^ d_q[N-2:0];
                    q_d[i_q] = 1'b1;
                end else begin
                    r_d      = t[N-2:0];
                    q_d[i_q] = 1'b0;
                end
                if (i_q == '0) begin
                    quot_d  = q_d;
                    rem_d   = {1'b0, r_d};
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    i_d = i_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            k_q     <= '0;
            deg_q   <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            k_q     <= k_d;
            deg_q   <= deg_d;
            i_q     <= i_d;
            done_q  <= done_d;
            err_q   <= err_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and property checks of the GF(2) divider at N=8, DW=16.
module tb_gf2_poly_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    int n_cmp  = 0;
    int n_fail = 0;

    gf2_poly_divider #(.N(8), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic [15:0] q;
        logic [7:0]  r;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] clmul(input logic [15:0] x, input logic [7:0] y);
        logic [31:0] acc;
        acc = '0;
        for (int b = 0; b < 8; b++)
            if (y[b]) acc = acc ^ ({16'h0, x} << b);
        return acc;
    endfunction

    function automatic int degof(input logic [7:0] v);
        int dg;
        dg = -1;
        for (int b = 0; b < 8; b++)
            if (v[b]) dg = b;
        return dg;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [7:0] d,
                          output logic [15:0] q, output logic [7:0] r, output logic e,
                          output int lat, output logic busy0, output logic busy_dn,
                          output logic done_nxt);
        @(negedge clk);
        dividend = a;
        divisor  = d;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy0 = busy;
        lat   = -1;
        for (int c = 0; c < 100; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        q       = quotient;
        r       = remainder;
        e       = err;
        busy_dn = busy;
        @(posedge clk);
        #1;
        done_nxt = done;
    endtask

    logic [15:0] q;
    logic [7:0]  r;
    logic        e, b0, bd, dn;
    int          lat;
    logic [31:0] prod;
    logic [7:0]  a8, b8;
    logic [15:0] ra;
    int          dg, ndone, dcnt;
    int          dt[4];
    logic [15:0] dq[4];
    logic [7:0]  dr[4];

    initial begin
        vecs[0] = '{16'h000A, 8'h03, 16'h0006, 8'h00, 1'b0, 23};
        vecs[1] = '{16'hABCD, 8'h80, 16'h0157, 8'h4D, 1'b0, 17};
        vecs[2] = '{16'hBEEF, 8'h01, 16'hBEEF, 8'h00, 1'b0, 24};
        vecs[3] = '{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 22};
        vecs[4] = '{16'h0007, 8'h0B, 16'h0000, 8'h07, 1'b0, 21};
        vecs[5] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17};
        vecs[6] = '{16'h0100, 8'h03, 16'h00FF, 8'h01, 1'b0, 23};
        vecs[7] = '{16'h00FF, 8'h04, 16'h003F, 8'h03, 1'b0, 22};
        vecs[8] = '{16'h1234, 8'h00, 16'h0000, 8'h00, 1'b1, 0};
        vecs[9] = '{16'h1234, 8'h02, 16'h091A, 8'h00, 1'b0, 23};

        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_err", {31'b0, err}, 0);
        chk("reset_q", {16'b0, quotient}, 0);
        chk("reset_r", {24'b0, remainder}, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].a, vecs[v].d, q, r, e, lat, b0, bd, dn);
            chk($sformatf("v%0d_q", v), {16'b0, q}, {16'b0, vecs[v].q});
            chk($sformatf("v%0d_r", v), {24'b0, r}, {24'b0, vecs[v].r});
            chk($sformatf("v%0d_err", v), {31'b0, e}, {31'b0, vecs[v].e});
            chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
            chk($sformatf("v%0d_busy_start", v), {31'b0, b0}, {31'b0, ~vecs[v].e});
            chk($sformatf("v%0d_busy_done", v), {31'b0, bd}, 0);
            chk($sformatf("v%0d_done_pulse", v), {31'b0, dn}, 0);
        end

        // reset mid-operation discards the job and clears all outputs
        @(negedge clk);
        dividend = 16'hABCD;
        divisor  = 8'h80;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_err", {31'b0, err}, 0);
        chk("midrst_q", {16'b0, quotient}, 0);
        chk("midrst_r", {24'b0, remainder}, 0);
        @(negedge clk);
        rst  = 1'b1;
        dcnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("midrst_no_done", 32'(dcnt), 0);
        run_op(16'h000A, 8'h03, q, r, e, lat, b0, bd, dn);
        chk("after_rst_q", {16'b0, q}, 32'h6);
        chk("after_rst_r", {24'b0, r}, 0);
        chk("after_rst_lat", 32'(lat), 23);

        // start held high; inputs changed while busy must not disturb the running job
        ndone = 0;
        @(negedge clk);
        dividend = 16'h000A;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) begin
                dividend = 16'hABCD;
                divisor  = 8'h80;
            end
            if (done) begin
                if (ndone < 4) begin
                    dt[ndone] = c;
                    dq[ndone] = quotient;
                    dr[ndone] = remainder;
                end
                chk("held_busy_at_done", {31'b0, busy}, 0);
                ndone++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_done_count", 32'(ndone), 3);
        if (ndone >= 3) begin
            chk("held_t0", 32'(dt[0]), 23);
            chk("held_q0", {16'b0, dq[0]}, 32'h6);
            chk("held_t1", 32'(dt[1]), 41);
            chk("held_q1", {16'b0, dq[1]}, 32'h157);
            chk("held_r1", {24'b0, dr[1]}, 32'h4D);
            chk("held_t2", 32'(dt[2]), 59);
        end
        repeat (30) @(posedge clk);

        // carry-less product divided by its factor recovers the other factor exactly
        for (int n = 0; n < 30; n++) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom_range(1, 255));
            prod = clmul({8'h0, a8}, b8);
            run_op(prod[15:0], b8, q, r, e, lat, b0, bd, dn);
            chk("prod_q", {16'b0, q}, {24'b0, a8});
            chk("prod_r", {24'b0, r}, 0);
        end

        // arbitrary A, D: reconstruction, remainder degree and latency
        for (int n = 0; n < 30; n++) begin
            ra   = 16'($urandom);
            b8   = 8'($urandom_range(1, 255));
            dg   = degof(b8);
            run_op(ra, b8, q, r, e, lat, b0, bd, dn);
            prod = clmul(q, b8) ^ {24'b0, r};
            chk("rand_recon", prod, {16'b0, ra});
            chk("rand_rdeg", {24'b0, r} >> dg, 0);
            chk("rand_lat", 32'(lat), 32'((8 - dg) + 16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
